// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the CPU memory-access responder: the FSM state
// encoding, the three legal access-width masks, the default region bases
// (also used by the CPU for its start address) and small mask helpers.
// -----------------------------------------------------------------------------
package mem_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAM_ACC,
        IO_ACC,
        RESP,
        ERR
    } busState_e;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    localparam logic [31:0] DEFAULT_RAM_BASE = 32'h4000_0000;
    localparam logic [31:0] DEFAULT_IO_BASE  = 32'h8000_0000;

    // True only for byte, half and word masks; anything else is a fault.
    function automatic logic maskLegal(input logic [3:0] mask);
        return (mask == MASK_BYTE) || (mask == MASK_HALF) || (mask == MASK_WORD);
    endfunction

    // Expands a byte mask into a 32-bit bit mask, used to zero-extend reads.
    function automatic logic [31:0] maskToBits(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/mem_bus_ram.sv
// -----------------------------------------------------------------------------
// mem_bus_ram
// Single-port synchronous RAM, 32-bit words, four byte enables, one-cycle
// read latency. Contents are never cleared.
//   clk       : clock
//   en_i      : access strobe for this cycle
//   we_i      : 1 = write enabled lanes, 0 = read word
//   be_i      : byte-lane enables for writes
//   addr_i    : word address
//   wdata_i   : lane-aligned write data
//   rdata_o   : word read on the previous enabled read cycle
// -----------------------------------------------------------------------------
module mem_bus_ram #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o
);

    logic [31:0] mem [0:(1 << ADDR_BITS) - 1];
    logic [31:0] rdata_q;

    // Writes update only the enabled lanes; reads register the whole word so
    // the data is available the cycle after the access strobe.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// -----------------------------------------------------------------------------
// mem_bus_responder
// Target side of the CPU memory-access handshake. Decodes each request to
// on-chip RAM or the external IO window, lane-aligns sub-word data and ends
// every transaction with exactly one ma_done (success) or ma_timeout (fault).
//   clk, rst              : clock, synchronous active-high reset
//   ma_addr/ma_data_in    : CPU byte address and right-justified write data
//   ma_rd_req/ma_wr_req   : CPU read / write request, held until done/timeout
//   ma_data_mask          : 0001 byte, 0011 half, 1111 word
//   ma_data_out           : right-justified, zero-extended read data
//   ma_done/ma_timeout    : one-cycle completion / fault pulses
//   io_addr/io_data_out   : IO window offset and lane-aligned write data
//   io_rd_req/io_wr_req   : IO requests, held until io_ack or timeout
//   io_byte_en/io_data_in : IO byte enables and lane-aligned read data
//   io_ack                : one-cycle IO completion
// -----------------------------------------------------------------------------
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] RAM_BASE       = DEFAULT_RAM_BASE,
    parameter int          RAM_ADDR_BITS  = 12,
    parameter int          RAM_WAIT       = 1,
    parameter logic [31:0] IO_BASE        = DEFAULT_IO_BASE,
    parameter int          IO_ADDR_BITS   = 16,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ma_addr,
    input  logic [31:0] ma_data_in,
    output logic [31:0] ma_data_out,
    input  logic        ma_rd_req,
    input  logic        ma_wr_req,
    input  logic [3:0]  ma_data_mask,
    output logic        ma_done,
    output logic        ma_timeout,
    output logic [31:0] io_addr,
    output logic [31:0] io_data_out,
    input  logic [31:0] io_data_in,
    output logic        io_rd_req,
    output logic        io_wr_req,
    output logic [3:0]  io_byte_en,
    input  logic        io_ack
);

    localparam int WAIT_W = $clog2(RAM_WAIT + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(RAM_WAIT - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]       IO_OFF_MASK = (32'd1 << IO_ADDR_BITS) - 32'd1;

    busState_e         state_q;
    logic              opWrite_q;
    logic              isRam_q;
    logic [31:0]       addr_q;
    logic [3:0]        mask_q;
    logic [3:0]        byteEn_q;
    logic [31:0]       laneData_q;
    logic [31:0]       ioWord_q;
    logic [WAIT_W-1:0] waitCnt_q;
    logic [TO_W-1:0]   toCnt_q;
    logic              ma_done_q;
    logic              ma_timeout_q;

    logic [6:0]  wideBe;
    logic [3:0]  byteEn_d;
    logic [31:0] laneData_d;
    logic        hitRam;
    logic        hitIo;
    logic        decodeFault;
    logic        ramAccess;
    logic        ioActive;
    logic [31:0] ramRdata;
    logic [31:0] respWord;

    // Request decode, evaluated every cycle but only latched in IDLE. The
    // mask is shifted into a 7-bit field so a sub-word access that would
    // spill past byte 3 shows up in the upper bits as a misalignment.
    always_comb begin
        wideBe      = {3'b000, ma_data_mask} << ma_addr[1:0];
        byteEn_d    = wideBe[3:0];
        laneData_d  = ma_data_in << {ma_addr[1:0], 3'b000};
        hitRam      = (ma_addr[31:RAM_ADDR_BITS+2] == RAM_BASE[31:RAM_ADDR_BITS+2]);
        hitIo       = (ma_addr[31:IO_ADDR_BITS] == IO_BASE[31:IO_ADDR_BITS]);
        decodeFault = (ma_rd_req && ma_wr_req) || !maskLegal(ma_data_mask)
                      || (|wideBe[6:4]) || !(hitRam || hitIo);
    end

    // The RAM is touched only in the last wait cycle. Gating with rst makes
    // a write caught by reset in its access cycle leave memory untouched.
    assign ramAccess = (state_q == RAM_ACC) && (waitCnt_q == WAIT_LAST);

    mem_bus_ram #(
        .ADDR_BITS (RAM_ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .en_i    (ramAccess && !rst),
        .we_i    (opWrite_q),
        .be_i    (byteEn_q),
        .addr_i  (addr_q[RAM_ADDR_BITS+1:2]),
        .wdata_i (laneData_q),
        .rdata_o (ramRdata)
    );

    // Main transaction FSM. Done/timeout pulses are set on the same edge that
    // enters RESP/ERR so they line up with those states, and every path out
    // of RESP/ERR clears them the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            opWrite_q    <= 1'b0;
            isRam_q      <= 1'b0;
            addr_q       <= '0;
            mask_q       <= '0;
            byteEn_q     <= '0;
            laneData_q   <= '0;
            ioWord_q     <= '0;
            waitCnt_q    <= '0;
            toCnt_q      <= '0;
            ma_done_q    <= 1'b0;
            ma_timeout_q <= 1'b0;
        end else begin
            ma_done_q    <= 1'b0;
            ma_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ma_rd_req || ma_wr_req) begin
                        opWrite_q  <= ma_wr_req;
                        isRam_q    <= hitRam;
                        addr_q     <= ma_addr;
                        mask_q     <= ma_data_mask;
                        byteEn_q   <= byteEn_d;
                        laneData_q <= laneData_d;
                        waitCnt_q  <= '0;
                        toCnt_q    <= '0;
                        if (decodeFault) begin
                            state_q      <= ERR;
                            ma_timeout_q <= 1'b1;
                        end else if (hitRam) begin
                            state_q <= RAM_ACC;
                        end else begin
                            state_q <= IO_ACC;
                        end
                    end
                end
                RAM_ACC: begin
                    if (waitCnt_q == WAIT_LAST) begin
                        state_q   <= RESP;
                        ma_done_q <= 1'b1;
                    end else begin
                        waitCnt_q <= waitCnt_q + WAIT_W'(1);
                    end
                end
                IO_ACC: begin
                    // Ack is checked first so it wins over an expiring counter.
                    if (io_ack) begin
                        ioWord_q  <= io_data_in;
                        state_q   <= RESP;
                        ma_done_q <= 1'b1;
                    end else if (toCnt_q == TO_LIMIT) begin
                        state_q      <= ERR;
                        ma_timeout_q <= 1'b1;
                    end else begin
                        toCnt_q <= toCnt_q + TO_W'(1);
                    end
                end
                RESP:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The IO request is held for TIMEOUT_CYCLES cycles; once the counter sits
    // at its limit the request is already down while the FSM waits one last
    // cycle for a late ack before declaring the fault.
    assign ioActive    = (state_q == IO_ACC) && (toCnt_q != TO_LIMIT);
    assign io_rd_req   = ioActive && !opWrite_q;
    assign io_wr_req   = ioActive && opWrite_q;
    assign io_addr     = ioActive ? (addr_q & IO_OFF_MASK) : '0;
    assign io_byte_en  = ioActive ? byteEn_q : '0;
    assign io_data_out = ioActive ? laneData_q : '0;

    // Read data is only presented during RESP of a read; it comes straight
    // from the RAM output register or the captured IO word, shifted down to
    // bit 0 and zero-extended above the access width.
    assign respWord    = isRam_q ? ramRdata : ioWord_q;
    assign ma_data_out = (state_q == RESP && !opWrite_q)
                         ? ((respWord >> {addr_q[1:0], 3'b000}) & maskToBits(mask_q))
                         : '0;

    assign ma_done    = ma_done_q;
    assign ma_timeout = ma_timeout_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_responder
// Self-checking bench for mem_bus_responder: a table of directed transactions
// with hand-computed results, plus hand-written reset-during-access sequences.
// -----------------------------------------------------------------------------
module tb_mem_bus_responder;

    localparam int MAX_CYCLES = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ma_addr;
    logic [31:0] ma_data_in;
    logic [31:0] ma_data_out;
    logic        ma_rd_req;
    logic        ma_wr_req;
    logic [3:0]  ma_data_mask;
    logic        ma_done;
    logic        ma_timeout;
    logic [31:0] io_addr;
    logic [31:0] io_data_out;
    logic [31:0] io_data_in;
    logic        io_rd_req;
    logic        io_wr_req;
    logic [3:0]  io_byte_en;
    logic        io_ack;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          ackCycle;
        logic [31:0] ackData;
        int          expDone;
        int          expTimeout;
        logic [31:0] expData;
        int          expIoCycles;
        logic [31:0] expIoAddr;
        logic [3:0]  expIoBe;
        logic [31:0] expIoData;
    } vector_t;

    vector_t vecs[$];

    mem_bus_responder dut (
        .clk          (clk),
        .rst          (rst),
        .ma_addr      (ma_addr),
        .ma_data_in   (ma_data_in),
        .ma_data_out  (ma_data_out),
        .ma_rd_req    (ma_rd_req),
        .ma_wr_req    (ma_wr_req),
        .ma_data_mask (ma_data_mask),
        .ma_done      (ma_done),
        .ma_timeout   (ma_timeout),
        .io_addr      (io_addr),
        .io_data_out  (io_data_out),
        .io_data_in   (io_data_in),
        .io_rd_req    (io_rd_req),
        .io_wr_req    (io_wr_req),
        .io_byte_en   (io_byte_en),
        .io_ack       (io_ack)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Hard stop in case a wait somewhere never resolves.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: bumps the counters and reports a mismatch.
    task automatic checkOutput(input string what, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", what, actual, expected);
        end
    endtask

    task automatic addVec(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input int ackCycle,
                          input logic [31:0] ackData, input int expDone,
                          input int expTimeout, input logic [31:0] expData,
                          input int expIoCycles, input logic [31:0] expIoAddr,
                          input logic [3:0] expIoBe, input logic [31:0] expIoData);
        vector_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.mask = mask; v.ackCycle = ackCycle; v.ackData = ackData;
        v.expDone = expDone; v.expTimeout = expTimeout; v.expData = expData;
        v.expIoCycles = expIoCycles; v.expIoAddr = expIoAddr;
        v.expIoBe = expIoBe; v.expIoData = expIoData;
        vecs.push_back(v);
    endtask

    // Drives one transaction, watches it cycle by cycle (cycle 0 is the first
    // cycle the request is visible), drops the request on the edge after the
    // pulse and checks every observed property against the vector.
    task automatic applyStimulus(input vector_t v);
        int          doneCyc    = -1;
        int          toCyc      = -1;
        int          ioCycles   = 0;
        int          extraPulse = 0;
        int          bothHigh   = 0;
        logic [31:0] dataSeen   = '0;
        logic [31:0] ioAddrSeen = '0;
        logic [3:0]  ioBeSeen   = '0;
        logic [31:0] ioDataSeen = '0;
        @(posedge clk);
        #1;
        ma_rd_req    = v.rd;
        ma_wr_req    = v.wr;
        ma_addr      = v.addr;
        ma_data_in   = v.wdata;
        ma_data_mask = v.mask;
        for (int n = 0; n <= MAX_CYCLES; n++) begin
            @(negedge clk);
            if (io_rd_req || io_wr_req) begin
                if (ioCycles == 0) begin
                    ioAddrSeen = io_addr;
                    ioBeSeen   = io_byte_en;
                    ioDataSeen = io_data_out;
                end
                ioCycles++;
            end
            if (ma_done && ma_timeout) bothHigh = 1;
            if (ma_done && doneCyc < 0) begin
                doneCyc  = n;
                dataSeen = ma_data_out;
            end
            if (ma_timeout && toCyc < 0) toCyc = n;
            io_ack     = (n == v.ackCycle);
            io_data_in = (n == v.ackCycle) ? v.ackData : 32'h0;
            if (doneCyc >= 0 || toCyc >= 0) break;
        end
        @(posedge clk);
        #1;
        ma_rd_req  = 1'b0;
        ma_wr_req  = 1'b0;
        io_ack     = 1'b0;
        io_data_in = 32'h0;
        @(negedge clk);
        if (ma_done || ma_timeout) extraPulse = 1;
        checkOutput({v.name, " doneCycle"}, doneCyc, v.expDone);
        checkOutput({v.name, " timeoutCycle"}, toCyc, v.expTimeout);
        checkOutput({v.name, " singlePulse"}, extraPulse + bothHigh, 0);
        checkOutput({v.name, " ioReqCycles"}, ioCycles, v.expIoCycles);
        if (v.rd && !v.wr && v.expDone >= 0)
            checkOutput({v.name, " readData"}, dataSeen, v.expData);
        if (v.expIoCycles > 0) begin
            checkOutput({v.name, " ioAddr"}, ioAddrSeen, v.expIoAddr);
            checkOutput({v.name, " ioByteEn"}, {28'h0, ioBeSeen}, {28'h0, v.expIoBe});
            checkOutput({v.name, " ioDataOut"}, ioDataSeen, v.expIoData);
        end
    endtask

    // Checks that every output sits at its reset value and no pulse is up.
    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " ctrl"},
                    {26'h0, ma_done, ma_timeout, io_rd_req, io_wr_req, 2'b00},
                    32'h0);
        checkOutput({tag, " ioByteEn"}, {28'h0, io_byte_en}, 32'h0);
        checkOutput({tag, " ioAddr"}, io_addr, 32'h0);
        checkOutput({tag, " ioDataOut"}, io_data_out, 32'h0);
        checkOutput({tag, " maDataOut"}, ma_data_out, 32'h0);
    endtask

    initial begin
        vector_t v;
        //      name               rd    wr    addr          wdata         mask  ack ackData       done to  expData      ioC ioAddr      be       ioData
        addVec("wordWr",          1'b0, 1'b1, 32'h40000010, 32'hDEADBEEF, 4'hF, -1, 32'h0,        2, -1, 32'h0,        0, 32'h0,      4'h0, 32'h0);
        addVec("wordRd",          1'b1, 1'b0, 32'h40000010, 32'h0,        4'hF, -1, 32'h0,        2, -1, 32'hDEADBEEF, 0, 32'h0,      4'h0, 32'h0);
        addVec("byteWr",          1'b0, 1'b1, 32'h40000013, 32'h000000AA, 4'h1, -1, 32'h0,        2, -1, 32'h0,        0, 32'h0,      4'h0, 32'h0);
        addVec("wordRdAfterByte", 1'b1, 1'b0, 32'h40000010, 32'h0,        4'hF, -1, 32'h0,        2, -1, 32'hAAADBEEF, 0, 32'h0,      4'h0, 32'h0);
        addVec("halfRd",          1'b1, 1'b0, 32'h40000012, 32'h0,        4'h3, -1, 32'h0,        2, -1, 32'h0000AAAD, 0, 32'h0,      4'h0, 32'h0);
        addVec("byteRd",          1'b1, 1'b0, 32'h40000011, 32'h0,        4'h1, -1, 32'h0,        2, -1, 32'h000000BE, 0, 32'h0,      4'h0, 32'h0);
        addVec("unmapped",        1'b1, 1'b0, 32'h20000000, 32'h0,        4'hF, -1, 32'h0,       -1,  1, 32'h0,        0, 32'h0,      4'h0, 32'h0);
        addVec("bothReq",         1'b1, 1'b1, 32'h40000010, 32'h0,        4'hF, -1, 32'h0,       -1,  1, 32'h0,        0, 32'h0,      4'h0, 32'h0);
        addVec("badMask",         1'b1, 1'b0, 32'h40000010, 32'h0,        4'h7, -1, 32'h0,       -1,  1, 32'h0,        0, 32'h0,      4'h0, 32'h0);
        addVec("misalignedHalf",  1'b1, 1'b0, 32'h40000013, 32'h0,        4'h3, -1, 32'h0,       -1,  1, 32'h0,        0, 32'h0,      4'h0, 32'h0);
        addVec("ioRd",            1'b1, 1'b0, 32'h80000004, 32'h0,        4'hF,  4, 32'h12345678, 5, -1, 32'h12345678, 4, 32'h4,      4'hF, 32'h0);
        addVec("ioByteWr",        1'b0, 1'b1, 32'h80000102, 32'h0000005A, 4'h1,  2, 32'h0,        3, -1, 32'h0,        2, 32'h102,    4'h4, 32'h005A0000);
        addVec("ioHalfRd",        1'b1, 1'b0, 32'h80000006, 32'h0,        4'h3,  1, 32'hBEEF0000, 2, -1, 32'h0000BEEF, 1, 32'h6,      4'hC, 32'h0);
        addVec("ioWrTimeout",     1'b0, 1'b1, 32'h80000020, 32'hCAFEF00D, 4'hF, -1, 32'h0,       -1, 18, 32'h0,       16, 32'h20,     4'hF, 32'hCAFEF00D);
        addVec("ramRdAfterTo",    1'b1, 1'b0, 32'h40000010, 32'h0,        4'hF, -1, 32'h0,        2, -1, 32'hAAADBEEF, 0, 32'h0,      4'h0, 32'h0);
        addVec("ioAckAtLimit",    1'b1, 1'b0, 32'h80000008, 32'h0,        4'hF, 17, 32'h0F0F0F0F,18, -1, 32'h0F0F0F0F,16, 32'h8,      4'hF, 32'h0);
        addVec("topWordWr",       1'b0, 1'b1, 32'h40003FFC, 32'h01020304, 4'hF, -1, 32'h0,        2, -1, 32'h0,        0, 32'h0,      4'h0, 32'h0);
        addVec("topWordRd",       1'b1, 1'b0, 32'h40003FFC, 32'h0,        4'hF, -1, 32'h0,        2, -1, 32'h01020304, 0, 32'h0,      4'h0, 32'h0);
        addVec("pastRamEnd",      1'b1, 1'b0, 32'h40004000, 32'h0,        4'hF, -1, 32'h0,       -1,  1, 32'h0,        0, 32'h0,      4'h0, 32'h0);
        addVec("ioWindowEnd",     1'b1, 1'b0, 32'h8000FFFF, 32'h0,        4'h1,  1, 32'hAB000000, 2, -1, 32'h000000AB, 1, 32'hFFFF,   4'h8, 32'h0);
        addVec("pastIoWindow",    1'b1, 1'b0, 32'h80010000, 32'h0,        4'hF, -1, 32'h0,       -1,  1, 32'h0,        0, 32'h0,      4'h0, 32'h0);

        rst          = 1'b1;
        ma_addr      = 32'h0;
        ma_data_in   = 32'h0;
        ma_rd_req    = 1'b0;
        ma_wr_req    = 1'b0;
        ma_data_mask = 4'h0;
        io_data_in   = 32'h0;
        io_ack       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset while a RAM write sits in its access cycle: no pulse, and the
        // word at 40000010 must still read back as before.
        @(posedge clk);
        #1;
        ma_wr_req = 1'b1; ma_addr = 32'h40000010;
        ma_data_in = 32'h11111111; ma_data_mask = 4'hF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkIdleOutputs("ramReset");
        rst = 1'b0; ma_wr_req = 1'b0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("ramResetQuiet");
        v = vecs[3];
        v.name = "rdAfterRamReset";
        applyStimulus(v);

        // Reset while an IO write is waiting for ack: request drops on the
        // reset edge and no pulse follows.
        @(posedge clk);
        #1;
        ma_wr_req = 1'b1; ma_addr = 32'h80000010;
        ma_data_in = 32'h00000077; ma_data_mask = 4'hF;
        repeat (4) @(negedge clk);
        checkOutput("ioResetPre wrReq", {31'h0, io_wr_req}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        checkIdleOutputs("ioReset");
        rst = 1'b0; ma_wr_req = 1'b0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("ioResetQuiet");
        v = vecs[12];
        v.name = "ioRdAfterReset";
        applyStimulus(v);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Target side of the CPU memory-access handshake (ma_rd_req/ma_wr_req, ma_done/ma_timeout).
- Decodes each request to on-chip RAM or an external IO port, lane-aligns sub-word data, and reports success or fault.
- Sits between the CPU core and memory/peripherals; it is the only responder on the CPU's access port.

Parameters:
- RAM_BASE, 32'h40000000, byte base address of on-chip RAM; must be aligned to the RAM size.
- RAM_ADDR_BITS, 12, log2 of the RAM depth in 32-bit words.
- RAM_WAIT, 1, wait cycles before a RAM access; must be ≥1.
- IO_BASE, 32'h80000000, byte base address of the IO window.
- IO_ADDR_BITS, 16, log2 of the IO window size in bytes.
- TIMEOUT_CYCLES, 16, IO cycles without io_ack before a fault is reported.

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- ma_addr in 32: byte address from the CPU.
- ma_data_in in 32: write data from the CPU, right-justified.
- ma_data_out out 32: read data to the CPU, right-justified.
- ma_rd_req in 1: read request.
- ma_wr_req in 1: write request.
- ma_data_mask in 4: 0001 = byte, 0011 = half, 1111 = word.
- ma_done out 1: one-cycle success pulse.
- ma_timeout out 1: one-cycle fault pulse.
- io_addr out 32: byte address offset within the IO window.
- io_data_out out 32: lane-aligned write data.
- io_data_in in 32: lane-aligned read data.
- io_rd_req out 1: IO read request.
- io_wr_req out 1: IO write request.
- io_byte_en out 4: IO byte enables.
- io_ack in 1: IO completion, one cycle.

Behaviour:
- Reset: state IDLE. ma_done, ma_timeout, io_rd_req and io_wr_req are 0. ma_data_out, io_addr, io_data_out and io_byte_en are 0. RAM contents are not cleared.
- Initiator contract: the request and its address, data and mask are held stable until the cycle after done/timeout is seen; the initiator drops the request on that edge.
- IDLE: samples requests each cycle. On ma_rd_req or ma_wr_req:
  - Latch op, addr, mask and data. Compute off = addr[1:0] and be = mask << off.
  - Lane data: wdata << 8*off.
  - Fault (go to ERR) if: both requests are high; mask is not one of the three legal values; mask << off exceeds 4 bits (misaligned); or the address is in neither region.
  - Otherwise go to RAM_ACC or IO_ACC.
- RAM_ACC:
  - Counts RAM_WAIT cycles.
  - In the last count cycle: write the enabled byte lanes, or read the word at addr[RAM_ADDR_BITS+1:2].
  - Next state RESP.
  - RAM never times out.
- IO_ACC:
  - io_*_req, io_addr, io_byte_en and io_data_out are driven from the latches while in this state.
  - io_ack: capture io_data_in, drop the request the next cycle, go to RESP.
  - Cycle counter reaches TIMEOUT_CYCLES with no ack: drop the request, go to ERR.
  - io_ack in the same cycle as the counter reaching its limit: ack wins.
- RESP:
  - ma_done = 1 for exactly one cycle.
  - For reads, ma_data_out = (word >> 8*off), zero-extended above the mask width. The CPU performs sign extension.
  - Go to IDLE.
- ERR: ma_timeout = 1 for exactly one cycle, then IDLE. ma_data_out = 0.
- ma_done and ma_timeout are never high together and are registered outputs.
- Latency with RAM_WAIT = 1:
  - Request first seen at cycle t.
  - ma_done at t+2; ma_timeout for a decode fault at t+1.
- IO latency: ma_done at the io_ack cycle + 1. Timeout at t + 1 + TIMEOUT_CYCLES + 1.
- Reset mid-operation: return to IDLE immediately. No done/timeout pulse is generated. IO requests drop the same edge. A pending RAM write that has not reached its access cycle is discarded.
- Request still high on return to IDLE: treated as a new transaction (the initiator contract prevents this).

Decomposition:
- Shared package mem_bus_pkg holds:
  - State encoding: IDLE, RAM_ACC, IO_ACC, RESP, ERR.
  - Legal mask constants.
  - Default region base constants, shared with the CPU start address.
- Sub-module mem_bus_ram: single-port synchronous RAM with 4 byte-enables, depth 2^RAM_ADDR_BITS, one-cycle read. Instantiated once.

Test Plan:
- Word write 32'hDEADBEEF to 40000010, then word read of 40000010 → ma_done at t+2 and ma_data_out = DEADBEEF.
- Byte write 32'h000000AA to 40000013, then word read of 40000010 → AAADBEEF. Half read of 40000012 → 0000AAAD.
- Read of 20000000 (unmapped) → ma_timeout high for one cycle at t+1, no ma_done, io_rd_req never asserted.
- IO read of 80000004 with io_ack after 3 cycles and io_data_in = 12345678 → io_byte_en = 1111, io_addr = 4, ma_done one cycle after ack with 12345678.
- IO write with io_ack never asserted → io_wr_req held for 16 cycles then dropped, single ma_timeout pulse. A following RAM read still completes normally.
- rst asserted during IO_ACC and during RAM_ACC of a write → outputs reach reset values next cycle, no pulse, and the RAM word is unchanged.
